// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//
// Gshare direction predictor with a direct-mapped branch target buffer,
// a non-speculative global history register and commit/mispredict counters.
//
// Ports
//   clk_i               clock, all state changes on the rising edge
//   reset_i             synchronous active-high reset
//   pc_fi_i             fetch PC (lookup is combinational)
//   pred_taken_fi_o     predicted taken (BTB hit AND PHT counter MSB)
//   pred_target_fi_o    predicted target, 0 on BTB miss
//   btb_hit_fi_o        BTB valid and tag match for pc_fi_i
//   pred_index_fi_o     PHT index used at fetch, returned later at update
//   update_valid_ex_i   resolved branch/jump present in EX
//   stall_ex_i          blocks the update while high
//   flush_ex_i          blocks the update while high
//   pc_ex_i             PC of the resolved instruction
//   update_index_ex_i   piped pred_index_fi_o
//   taken_ex_i          actual outcome
//   target_ex_i         actual target
//   pred_taken_ex_i     piped prediction
//   pred_target_ex_i    piped predicted target
//   mispredict_ex_o     combinational misprediction flag (not stall/flush gated)
//   branch_count_o      number of committed updates
//   mispredict_count_o  number of committed mispredictions

module gshare_branch_predictor #(
    parameter int PHT_ENTRIES = 256,
    parameter int GHR_WIDTH   = 8,
    parameter int BTB_ENTRIES = 64,
    localparam int IDX        = $clog2(PHT_ENTRIES),
    localparam int BIDX       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [31:0]     pc_fi_i,
    output logic            pred_taken_fi_o,
    output logic [31:0]     pred_target_fi_o,
    output logic            btb_hit_fi_o,
    output logic [IDX-1:0]  pred_index_fi_o,
    input  logic            update_valid_ex_i,
    input  logic            stall_ex_i,
    input  logic            flush_ex_i,
    input  logic [31:0]     pc_ex_i,
    input  logic [IDX-1:0]  update_index_ex_i,
    input  logic            taken_ex_i,
    input  logic [31:0]     target_ex_i,
    input  logic            pred_taken_ex_i,
    input  logic [31:0]     pred_target_ex_i,
    output logic            mispredict_ex_o,
    output logic [31:0]     branch_count_o,
    output logic [31:0]     mispredict_count_o
);

    localparam int TAG_W = 32 - (BIDX + 2);

    // Two-bit saturating counter step.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == 2'b11) begin
                nxt = 2'b11;
            end else begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr == 2'b00) begin
                nxt = 2'b00;
            end else begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

    // State
    logic [1:0]             pht_q [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [31:0]            btb_target_q [BTB_ENTRIES];
    logic [31:0]            branch_count_q, branch_count_d;
    logic [31:0]            mispredict_count_q, mispredict_count_d;

    // Lookup / update helper signals
    logic [IDX-1:0]         ghr_ext_s;
    logic [IDX-1:0]         fetch_index_s;
    logic [BIDX-1:0]        fetch_set_s;
    logic [TAG_W-1:0]       fetch_tag_s;
    logic                   fetch_hit_s;
    logic [BIDX-1:0]        update_set_s;
    logic [TAG_W-1:0]       update_tag_s;
    logic                   commit_s;
    logic                   mispredict_s;
    logic [1:0]             pht_next_s;
    logic [GHR_WIDTH:0]     ghr_shift_s;
    logic                   unused_s;

    // The low two PC bits never address anything (instructions are word aligned).
    assign unused_s = ^{pc_fi_i[1:0], pc_ex_i[1:0]};

    assign fetch_set_s  = pc_fi_i[BIDX+1:2];
    assign fetch_tag_s  = pc_fi_i[31:BIDX+2];
    assign update_set_s = pc_ex_i[BIDX+1:2];
    assign update_tag_s = pc_ex_i[31:BIDX+2];

    // Fetch-side lookup: gshare index, BTB tag compare, prediction.
    always_comb begin
        ghr_ext_s                  = '0;
        ghr_ext_s[GHR_WIDTH-1:0]   = ghr_q;
        fetch_index_s              = pc_fi_i[IDX+1:2] ^ ghr_ext_s;
        fetch_hit_s                = btb_valid_q[fetch_set_s] && (btb_tag_q[fetch_set_s] == fetch_tag_s);
        if (fetch_hit_s) begin
            pred_target_fi_o = btb_target_q[fetch_set_s];
            pred_taken_fi_o  = pht_q[fetch_index_s][1];
        end else begin
            pred_target_fi_o = 32'd0;
            pred_taken_fi_o  = 1'b0;
        end
    end

    assign btb_hit_fi_o    = fetch_hit_s;
    assign pred_index_fi_o = fetch_index_s;

    // Execute-side resolution: mispredict flag is ungated, commit is gated.
    always_comb begin
        mispredict_s = update_valid_ex_i &&
                       ((taken_ex_i != pred_taken_ex_i) ||
                        (taken_ex_i && (target_ex_i != pred_target_ex_i)));
        commit_s     = update_valid_ex_i && !stall_ex_i && !flush_ex_i;
        pht_next_s   = sat_step(pht_q[update_index_ex_i], taken_ex_i);
        // Shifting through a (GHR_WIDTH+1)-bit vector covers GHR_WIDTH = 1 too.
        ghr_shift_s  = {ghr_q, taken_ex_i};
    end

    assign mispredict_ex_o = mispredict_s;

    // Next-state for history and counters.
    always_comb begin
        ghr_d              = ghr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (commit_s) begin
            ghr_d          = ghr_shift_s[GHR_WIDTH-1:0];
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict_s) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
        end else begin
            ghr_d          = ghr_q;
            branch_count_d = branch_count_q;
        end
    end

    // State update; reset wins over a same-cycle commit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ghr_q              <= '0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
            btb_valid_q        <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            ghr_q              <= ghr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (commit_s) begin
                pht_q[update_index_ex_i] <= pht_next_s;
            end
            // Only taken outcomes allocate; aliasing entries are overwritten.
            if (commit_s && taken_ex_i) begin
                btb_valid_q[update_set_s]  <= 1'b1;
                btb_tag_q[update_set_s]    <= update_tag_s;
                btb_target_q[update_set_s] <= target_ex_i;
            end
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
//
// Directed bench for gshare_branch_predictor at default parameters
// (PHT 256, GHR 8, BTB 64). Expected values are hand-computed; the GHR
// is observed through pred_index_fi_o at pc 0, where the index equals it.

module tb_gshare_branch_predictor;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] pc_fi_i;
    logic        pred_taken_fi_o;
    logic [31:0] pred_target_fi_o;
    logic        btb_hit_fi_o;
    logic [7:0]  pred_index_fi_o;
    logic        update_valid_ex_i;
    logic        stall_ex_i;
    logic        flush_ex_i;
    logic [31:0] pc_ex_i;
    logic [7:0]  update_index_ex_i;
    logic        taken_ex_i;
    logic [31:0] target_ex_i;
    logic        pred_taken_ex_i;
    logic [31:0] pred_target_ex_i;
    logic        mispredict_ex_o;
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;

    int errors = 0;
    int checks = 0;

    gshare_branch_predictor dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .pc_fi_i            (pc_fi_i),
        .pred_taken_fi_o    (pred_taken_fi_o),
        .pred_target_fi_o   (pred_target_fi_o),
        .btb_hit_fi_o       (btb_hit_fi_o),
        .pred_index_fi_o    (pred_index_fi_o),
        .update_valid_ex_i  (update_valid_ex_i),
        .stall_ex_i         (stall_ex_i),
        .flush_ex_i         (flush_ex_i),
        .pc_ex_i            (pc_ex_i),
        .update_index_ex_i  (update_index_ex_i),
        .taken_ex_i         (taken_ex_i),
        .target_ex_i        (target_ex_i),
        .pred_taken_ex_i    (pred_taken_ex_i),
        .pred_target_ex_i   (pred_target_ex_i),
        .mispredict_ex_o    (mispredict_ex_o),
        .branch_count_o     (branch_count_o),
        .mispredict_count_o (mispredict_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply fetch PC and let the combinational lookup settle.
    task automatic look(input logic [31:0] pc);
        pc_fi_i = pc;
        #1;
    endtask

    // Present an update for one clock edge, then withdraw it.
    task automatic commit(input logic [31:0] pc, input logic [7:0] idx, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        update_valid_ex_i = 1'b1;
        stall_ex_i        = 1'b0;
        flush_ex_i        = 1'b0;
        pc_ex_i           = pc;
        update_index_ex_i = idx;
        taken_ex_i        = t;
        target_ex_i       = tgt;
        pred_taken_ex_i   = pt;
        pred_target_ex_i  = ptgt;
        @(posedge clk_i);
        #1;
        update_valid_ex_i = 1'b0;
    endtask

    initial begin
        reset_i           = 1'b1;
        pc_fi_i           = 32'd0;
        update_valid_ex_i = 1'b0;
        stall_ex_i        = 1'b0;
        flush_ex_i        = 1'b0;
        pc_ex_i           = 32'd0;
        update_index_ex_i = 8'd0;
        taken_ex_i        = 1'b0;
        target_ex_i       = 32'd0;
        pred_taken_ex_i   = 1'b0;
        pred_target_ex_i  = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Post-reset lookup
        look(32'h100);
        chk("rst_taken",  {31'd0, pred_taken_fi_o}, 32'd0);
        chk("rst_hit",    {31'd0, btb_hit_fi_o},    32'd0);
        chk("rst_target", pred_target_fi_o,         32'd0);
        chk("rst_index",  {24'd0, pred_index_fi_o}, 32'h40);
        chk("rst_bcnt",   branch_count_o,           32'd0);
        chk("rst_mcnt",   mispredict_count_o,       32'd0);
        chk("rst_misp",   {31'd0, mispredict_ex_o}, 32'd0);

        // First commit: taken at 0x100, predicted not-taken -> mispredict
        update_valid_ex_i = 1'b1;
        taken_ex_i        = 1'b1;
        pred_taken_ex_i   = 1'b0;
        #1;
        chk("c1_misp_flag", {31'd0, mispredict_ex_o}, 32'd1);
        commit(32'h100, 8'h40, 1'b1, 32'h200, 1'b0, 32'd0);
        look(32'h100);
        chk("c1_index",  {24'd0, pred_index_fi_o}, 32'h41);
        chk("c1_hit",    {31'd0, btb_hit_fi_o},    32'd1);
        chk("c1_target", pred_target_fi_o,         32'h200);
        chk("c1_taken",  {31'd0, pred_taken_fi_o}, 32'd0);
        chk("c1_bcnt",   branch_count_o,           32'd1);
        chk("c1_mcnt",   mispredict_count_o,       32'd1);

        // Populate BTB entries used to observe PHT[0x10] under the GHR values to come
        commit(32'h3BC, 8'hA0, 1'b1, 32'h1000, 1'b1, 32'h1000);
        commit(32'h3B8, 8'hA0, 1'b1, 32'h1004, 1'b1, 32'h1004);
        commit(32'h3B0, 8'hA0, 1'b1, 32'h1008, 1'b1, 32'h1008);
        commit(32'h3C0, 8'hA0, 1'b1, 32'h100C, 1'b1, 32'h100C);
        look(32'h0);
        chk("pre_ghr", {24'd0, pred_index_fi_o}, 32'h1F);

        // Saturation on PHT[0x10]: three taken -> 11 (GHR 0xFF)
        commit(32'h3BC, 8'h10, 1'b1, 32'h1000, 1'b1, 32'h1000);
        commit(32'h3BC, 8'h10, 1'b1, 32'h1000, 1'b1, 32'h1000);
        commit(32'h3BC, 8'h10, 1'b1, 32'h1000, 1'b1, 32'h1000);
        look(32'h3BC);
        chk("satA_index",  {24'd0, pred_index_fi_o}, 32'h10);
        chk("satA_hit",    {31'd0, btb_hit_fi_o},    32'd1);
        chk("satA_target", pred_target_fi_o,         32'h1000);
        chk("satA_taken",  {31'd0, pred_taken_fi_o}, 32'd1);
        // Fourth taken stays at 11
        commit(32'h3BC, 8'h10, 1'b1, 32'h1000, 1'b1, 32'h1000);
        look(32'h3BC);
        chk("satB_index", {24'd0, pred_index_fi_o}, 32'h10);
        chk("satB_taken", {31'd0, pred_taken_fi_o}, 32'd1);
        // One not-taken -> 10, still taken (GHR 0xFE)
        commit(32'h3BC, 8'h10, 1'b0, 32'd0, 1'b0, 32'd0);
        look(32'h3B8);
        chk("satC_index", {24'd0, pred_index_fi_o}, 32'h10);
        chk("satC_hit",   {31'd0, btb_hit_fi_o},    32'd1);
        chk("satC_taken", {31'd0, pred_taken_fi_o}, 32'd1);
        // -> 01 (GHR 0xFC)
        commit(32'h3BC, 8'h10, 1'b0, 32'd0, 1'b0, 32'd0);
        look(32'h3B0);
        chk("satD_index", {24'd0, pred_index_fi_o}, 32'h10);
        chk("satD_hit",   {31'd0, btb_hit_fi_o},    32'd1);
        chk("satD_taken", {31'd0, pred_taken_fi_o}, 32'd0);
        // -> 00, 00, 00 (GHR 0xE0)
        commit(32'h3BC, 8'h10, 1'b0, 32'd0, 1'b0, 32'd0);
        commit(32'h3BC, 8'h10, 1'b0, 32'd0, 1'b0, 32'd0);
        commit(32'h3BC, 8'h10, 1'b0, 32'd0, 1'b0, 32'd0);
        look(32'h3C0);
        chk("satE_index",  {24'd0, pred_index_fi_o}, 32'h10);
        chk("satE_hit",    {31'd0, btb_hit_fi_o},    32'd1);
        chk("satE_target", pred_target_fi_o,         32'h100C);
        chk("satE_taken",  {31'd0, pred_taken_fi_o}, 32'd0);
        chk("sat_bcnt",    branch_count_o,           32'd14);
        chk("sat_mcnt",    mispredict_count_o,       32'd1);

        // Target mispredict: predicted taken to 0x200, actually taken to 0x300
        update_valid_ex_i = 1'b1;
        taken_ex_i        = 1'b1;
        target_ex_i       = 32'h300;
        pred_taken_ex_i   = 1'b1;
        pred_target_ex_i  = 32'h200;
        #1;
        chk("tgt_misp_flag", {31'd0, mispredict_ex_o}, 32'd1);
        commit(32'h80, 8'h22, 1'b1, 32'h300, 1'b1, 32'h200);
        chk("tgt_bcnt", branch_count_o,     32'd15);
        chk("tgt_mcnt", mispredict_count_o, 32'd2);
        look(32'h80);
        chk("tgt_index",  {24'd0, pred_index_fi_o}, 32'hE1);
        chk("tgt_hit",    {31'd0, btb_hit_fi_o},    32'd1);
        chk("tgt_target", pred_target_fi_o,         32'h300);

        // Same stimulus under flush: flag still raised, nothing committed
        update_valid_ex_i = 1'b1;
        flush_ex_i        = 1'b1;
        pc_ex_i           = 32'h84;
        update_index_ex_i = 8'h23;
        taken_ex_i        = 1'b1;
        target_ex_i       = 32'h300;
        pred_taken_ex_i   = 1'b1;
        pred_target_ex_i  = 32'h200;
        #1;
        chk("fl_misp_flag", {31'd0, mispredict_ex_o}, 32'd1);
        @(posedge clk_i);
        #1;
        update_valid_ex_i = 1'b0;
        flush_ex_i        = 1'b0;
        chk("fl_bcnt", branch_count_o,     32'd15);
        chk("fl_mcnt", mispredict_count_o, 32'd2);
        look(32'h0);
        chk("fl_ghr", {24'd0, pred_index_fi_o}, 32'hC1);
        look(32'h84);
        chk("fl_hit", {31'd0, btb_hit_fi_o}, 32'd0);

        // Stalled update held for two edges, then commits exactly once
        update_valid_ex_i = 1'b1;
        stall_ex_i        = 1'b1;
        pred_target_ex_i  = 32'h300;
        repeat (2) @(posedge clk_i);
        #1;
        chk("st_held_bcnt", branch_count_o, 32'd15);
        look(32'h84);
        chk("st_held_hit", {31'd0, btb_hit_fi_o}, 32'd0);
        stall_ex_i = 1'b0;
        @(posedge clk_i);
        #1;
        update_valid_ex_i = 1'b0;
        chk("st_bcnt", branch_count_o,     32'd16);
        chk("st_mcnt", mispredict_count_o, 32'd2);
        look(32'h0);
        chk("st_ghr", {24'd0, pred_index_fi_o}, 32'h83);
        look(32'h84);
        chk("st_hit",    {31'd0, btb_hit_fi_o}, 32'd1);
        chk("st_target", pred_target_fi_o,      32'h300);

        // Ungated flag is still qualified by update_valid
        taken_ex_i      = 1'b1;
        pred_taken_ex_i = 1'b0;
        #1;
        chk("novalid_misp", {31'd0, mispredict_ex_o}, 32'd0);

        // BTB alias: 0x200 shares set 0 with 0x100; no bypass during the write cycle
        update_valid_ex_i = 1'b1;
        pc_ex_i           = 32'h200;
        update_index_ex_i = 8'h55;
        taken_ex_i        = 1'b1;
        target_ex_i       = 32'h400;
        pred_taken_ex_i   = 1'b1;
        pred_target_ex_i  = 32'h400;
        look(32'h200);
        chk("al_nobypass_hit", {31'd0, btb_hit_fi_o}, 32'd0);
        commit(32'h200, 8'h55, 1'b1, 32'h400, 1'b1, 32'h400);
        look(32'h100);
        chk("al_old_hit",    {31'd0, btb_hit_fi_o}, 32'd0);
        chk("al_old_target", pred_target_fi_o,      32'd0);
        look(32'h200);
        chk("al_new_hit",    {31'd0, btb_hit_fi_o}, 32'd1);
        chk("al_new_target", pred_target_fi_o,      32'h400);
        chk("al_bcnt",       branch_count_o,        32'd17);
        look(32'h0);
        chk("al_ghr", {24'd0, pred_index_fi_o}, 32'h07);

        // Reset mid-stream with a commit in the same cycle
        reset_i           = 1'b1;
        update_valid_ex_i = 1'b1;
        stall_ex_i        = 1'b0;
        flush_ex_i        = 1'b0;
        pc_ex_i           = 32'h300;
        update_index_ex_i = 8'h11;
        taken_ex_i        = 1'b1;
        target_ex_i       = 32'h600;
        pred_taken_ex_i   = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i           = 1'b0;
        update_valid_ex_i = 1'b0;
        chk("mr_bcnt", branch_count_o,     32'd0);
        chk("mr_mcnt", mispredict_count_o, 32'd0);
        look(32'h0);
        chk("mr_ghr", {24'd0, pred_index_fi_o}, 32'h00);
        look(32'h100);
        chk("mr_hit_100",   {31'd0, btb_hit_fi_o},    32'd0);
        chk("mr_index_100", {24'd0, pred_index_fi_o}, 32'h40);
        look(32'h200);
        chk("mr_hit_200", {31'd0, btb_hit_fi_o}, 32'd0);
        look(32'h300);
        chk("mr_hit_300", {31'd0, btb_hit_fi_o}, 32'd0);

        // Normal operation resumes after reset
        commit(32'h100, 8'h40, 1'b1, 32'h200, 1'b0, 32'd0);
        look(32'h100);
        chk("pr_index",  {24'd0, pred_index_fi_o}, 32'h41);
        chk("pr_hit",    {31'd0, btb_hit_fi_o},    32'd1);
        chk("pr_target", pred_target_fi_o,         32'h200);
        chk("pr_bcnt",   branch_count_o,           32'd1);
        chk("pr_mcnt",   mispredict_count_o,       32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised gshare direction predictor with a direct-mapped branch target buffer (BTB), global history register (GHR) and performance counters. It is the next-generation predictor for the pipelined RISC-V core and replaces the fixed-size local predictor. Lookup is combinational from the fetch PC. Resolution updates arrive from the execute stage one branch at a time. The PHT index used at fetch is piped down the pipeline and returned at update, so training hits the same entry that made the prediction.

## Interface
Parameters:
- PHT_ENTRIES, 256: pattern history table depth; power of 2, ≥ 4; IDX = log2(PHT_ENTRIES).
- GHR_WIDTH, 8: global history length; 1 ≤ GHR_WIDTH ≤ IDX.
- BTB_ENTRIES, 64: BTB depth; power of 2, ≥ 2; BIDX = log2(BTB_ENTRIES); tag = pc[31:BIDX+2].

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- pc_fi_i  in  32  fetch PC.
- pred_taken_fi_o  out  1  predicted taken.
- pred_target_fi_o  out  32  predicted target; 0 on BTB miss.
- btb_hit_fi_o  out  1  BTB valid and tag match for pc_fi_i.
- pred_index_fi_o  out  IDX  PHT index used; piped to EX by the datapath.
- update_valid_ex_i  in  1  resolved branch/jump present in EX.
- stall_ex_i, flush_ex_i  in  1  each; either one blocks the update.
- pc_ex_i  in  32  PC of the resolved instruction.
- update_index_ex_i  in  IDX  piped pred_index_fi_o.
- taken_ex_i  in  1  actual outcome.
- target_ex_i  in  32  actual target.
- pred_taken_ex_i  in  1  piped prediction.
- pred_target_ex_i  in  32  piped predicted target.
- mispredict_ex_o  out  1  combinational misprediction flag.
- branch_count_o  out  32  committed updates.
- mispredict_count_o  out  32  committed mispredictions.

## Operation
- Index: pred_index_fi_o = pc_fi_i[IDX+1:2] XOR zero-extended GHR.
- PHT: 2-bit saturating counters; reset value 2'b01 (weakly not-taken).
- Prediction: pred_taken_fi_o = btb_hit_fi_o AND PHT[index][1]. A BTB miss always predicts not-taken.
- BTB: entry = {valid, tag, target}. Set = pc[BIDX+1:2]. Reset clears all valid bits; tag and target are don't-care.
- Commit: commit = update_valid_ex_i AND NOT stall_ex_i AND NOT flush_ex_i. When commit is high:
  - PHT[update_index_ex_i] increments if taken_ex_i, otherwise decrements; saturates at 2'b11 / 2'b00.
  - GHR <= {GHR[GHR_WIDTH-2:0], taken_ex_i}. For GHR_WIDTH = 1, GHR <= taken_ex_i. GHR is non-speculative.
  - If taken_ex_i, the BTB set of pc_ex_i is written valid with its tag and target_ex_i, overwriting any aliasing entry. A not-taken outcome leaves the BTB untouched.
  - branch_count_o increments; mispredict_count_o increments if mispredict_ex_o. Both wrap at 2^32.
- mispredict_ex_o = update_valid_ex_i AND ((taken_ex_i != pred_taken_ex_i) OR (taken_ex_i AND target_ex_i != pred_target_ex_i)). It is not gated by stall or flush; the counters use the gated form.
- Reset: GHR = 0, all PHT entries 01, all BTB entries invalid, both counters 0. With this state, pred_taken_fi_o = 0, btb_hit_fi_o = 0, pred_target_fi_o = 0.

## Timing
- Lookup: zero latency; outputs are combinational from pc_fi_i and registered state.
- Update: one cycle. State written on edge N is visible to lookup after edge N.
- Same-cycle lookup and update to the same PHT entry or BTB set: lookup returns the old value (no bypass).
- One update per cycle; back-to-back commits every cycle are supported.
- Reset has priority over commit in the same cycle. Reset asserted mid-stream restores full reset state at the next edge.
- A stalled update that is held in EX commits exactly once, on the first cycle with stall_ex_i = 0.

## Test plan
Defaults: PHT 256, GHR 8, BTB 64.
- Post-reset lookup at pc_fi_i = 0x100 -> pred_taken_fi_o = 0, btb_hit_fi_o = 0, pred_target_fi_o = 0, pred_index_fi_o = 0x40.
- Commit pc 0x100, index 0x40, taken, target 0x200 -> PHT[0x40] = 10, GHR = 0x01; next lookup at 0x100 -> index 0x41, btb_hit_fi_o = 1, pred_target_fi_o = 0x200, pred_taken_fi_o = 0 (PHT[0x41] = 01).
- Saturation on index 0x10: three taken commits -> 11 (stays 11); one not-taken -> 10, still predicts taken; four more not-taken -> 00 (stays 00).
- Mispredict: pred_taken_ex_i = 1, pred_target_ex_i = 0x200, taken_ex_i = 1, target 0x300 -> mispredict_ex_o = 1 and mispredict_count_o +1. Same stimulus with flush_ex_i = 1 -> counters, PHT, GHR and BTB unchanged.
- BTB alias: commit taken at pc 0x100, then taken at pc 0x200 (both map to set 0) -> lookup at 0x100 gives btb_hit_fi_o = 0; lookup at 0x200 gives btb_hit_fi_o = 1.
- Reset mid-stream after several commits -> GHR = 0, both counters 0, lookup at 0x100 gives btb_hit_fi_o = 0; commit asserted during the reset cycle is ignored.
